stack_pointer: RTL and testbench
================================

STACK_POINTER -- requirements
Module: stack_pointer

Interface
REQ-001 Parameter WIDTH, default 8: pointer and data-bus width in bits, range 4..16.
REQ-002 Parameter STACK_BASE, default 2**WIDTH-1: empty-stack pointer value, the topmost slot.
REQ-003 Parameter STACK_LIMIT, default 1: lowest usable slot; legal range 1 <= STACK_LIMIT <= STACK_BASE.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clk_en  input  1  global step enable; no state changes in a cycle where it is low.
REQ-007 oe  input  1  drive SP onto dataBus.
REQ-008 wr  input  1  load SP from dataBus.
REQ-009 push  input  1  push request: slot = SP, then SP decrements.
REQ-010 pop  input  1  pop request: slot = SP+1, then SP increments.
REQ-011 dataBus  inout  WIDTH  shared bus; driven only while oe=1, else high-Z.
REQ-012 addrOut  output  WIDTH  stack slot address for the current cycle.
REQ-013 full  output  1  combinational: SP == STACK_LIMIT-1.
REQ-014 empty  output  1  combinational: SP == STACK_BASE.
REQ-015 ovf  output  1  sticky overflow flag, registered.
REQ-016 unf  output  1  sticky underflow flag, registered.

Function
REQ-017 SP shall be an empty-descending pointer: it always addresses the next free slot.
REQ-018 addrOut shall equal SP+1 (mod 2**WIDTH) when pop=1 and the pop is accepted, else SP; it is combinational.
REQ-019 When oe=1, dataBus shall carry SP; when oe=0, dataBus shall be high-Z and sampled as load data.
REQ-020 Per-cycle priority with clk_en=1: wr (only when oe=0) > push&pop together > push > pop > hold.
REQ-021 wr=1, oe=0: SP <= dataBus next edge; ovf and unf cleared on the same edge; push/pop ignored.
REQ-022 wr=1, oe=1: wr ignored, evaluation proceeds with push/pop as if wr=0.
REQ-023 push=1 and pop=1 together: SP unchanged, no flag change, addrOut = SP.
REQ-024 Accepted push: SP <= SP-1; accepted pop: SP <= SP+1; arithmetic modulo 2**WIDTH.
REQ-025 Single-cycle latency: new SP visible on addrOut, full, empty, and dataBus in the cycle after the edge.
REQ-026 clk_en=0: SP, ovf, unf hold; addrOut, full, empty still track current inputs combinationally.

Reset
REQ-027 rst=1 shall immediately set SP=STACK_BASE, ovf=0, unf=0 regardless of clk or clk_en.
REQ-028 Following rst: addrOut=STACK_BASE, empty=1, full=0, dataBus high-Z unless oe=1.
REQ-029 Reset asserted mid-operation shall discard any pending push/pop/wr of that cycle.
REQ-030 Flags cleared only by rst or an accepted wr.

Configuration
REQ-031 Macro SP_BOUNDS_CHECK_EN shall compile in bounds protection.
REQ-032 Defined: push while full rejected, SP held, ovf<=1; pop while empty rejected, SP held, unf<=1, addrOut=SP.
REQ-033 Not defined: every push/pop accepted, SP wraps modulo 2**WIDTH, ovf and unf tied 0; full/empty still reported.
REQ-034 wr is never bounds-checked; out-of-range loads accepted in both builds.

Verification
REQ-035 Reset, WIDTH=8 defaults: rst pulse mid-clock -> SP=FF immediately, empty=1, ovf=unf=0, dataBus Z.
REQ-036 Push x3 from FF -> addrOut FF,FE,FD on push cycles; SP=FC after; pop x1 -> addrOut FD, SP=FD.
REQ-037 wr with dataBus=01, then push, then push (checks on) -> SP=00 full=1; second push: ovf=1, SP stays 00.
REQ-038 Pop at SP=FF, checks on -> unf=1, SP=FF, addrOut=FF; checks off -> SP=00, addrOut=00, unf=0.
REQ-039 push=pop=1 at SP=80 -> SP=80, flags unchanged; oe=1 with wr=1 and push=1 -> dataBus=80, SP=7F.
REQ-040 clk_en=0 with push held 4 cycles -> SP unchanged; WIDTH=4 build: push at SP=1, checks off, wraps to F after 2 pushes.

Source files
------------

// File: rtl/stack_pointer.sv
// ---------------------------------------------------------------------------
// stack_pointer
//    Empty-descending hardware stack pointer. SP always addresses the next
//    free slot: a push writes slot SP and then decrements, and a pop reads
//    slot SP+1 and then increments. SP can be loaded from, and driven onto,
//    a shared tri-state data bus.
//
// Configuration macro:
//    SP_BOUNDS_CHECK_EN - when defined, a push while full or a pop while
//                         empty is rejected. SP holds and the sticky
//                         ovf/unf flag is set. When undefined, every push
//                         and pop is accepted, SP wraps, and ovf/unf
//                         stay 0.
//
// Parameters:
//    WIDTH       pointer / bus width (4..16)
//    STACK_BASE  empty-stack SP value (topmost slot)
//    STACK_LIMIT lowest usable slot (full when SP == STACK_LIMIT-1)
//
// Ports:
//    clk      rising-edge clock
//    rst      asynchronous active-high reset
//    clk_en   global step enable
//    oe       drive SP onto dataBus
//    wr       load SP from dataBus (ignored while oe=1)
//    push     push request
//    pop      pop request
//    dataBus  shared bus, driven only while oe=1
//    addrOut  stack slot address for this cycle
//    full     SP == STACK_LIMIT-1
//    empty    SP == STACK_BASE
//    ovf      sticky overflow flag
//    unf      sticky underflow flag
// ---------------------------------------------------------------------------
module stack_pointer #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned STACK_BASE  = (2**WIDTH) - 1,
   parameter int unsigned STACK_LIMIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             oe,
   input  logic             wr,
   input  logic             push,
   input  logic             pop,
   inout  tri   [WIDTH-1:0] dataBus,
   output logic [WIDTH-1:0] addrOut,
   output logic             full,
   output logic             empty,
   output logic             ovf,
   output logic             unf
);

   localparam logic [WIDTH-1:0] BASE_VAL = WIDTH'(STACK_BASE);
   localparam logic [WIDTH-1:0] FULL_VAL = WIDTH'(STACK_LIMIT - 1);

   logic [WIDTH-1:0] sp_q, sp_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic wr_acc;
   logic push_only, pop_only;
   logic push_acc, pop_acc;
   logic push_rej, pop_rej;

   assign full  = (sp_q == FULL_VAL);
   assign empty = (sp_q == BASE_VAL);

   // A load only happens while the bus is not being driven by us; with oe=1
   // the wr request is dropped and push/pop evaluate normally.
   assign wr_acc    = wr & ~oe;
   assign push_only = ~wr_acc & push & ~pop;
   assign pop_only  = ~wr_acc & pop & ~push;

`ifdef SP_BOUNDS_CHECK_EN
   assign push_acc = push_only & ~full;
   assign pop_acc  = pop_only & ~empty;
   assign push_rej = push_only & full;
   assign pop_rej  = pop_only & empty;
`else
   assign push_acc = push_only;
   assign pop_acc  = pop_only;
   assign push_rej = 1'b0;
   assign pop_rej  = 1'b0;
`endif

   // Acceptance is evaluated independently of clk_en so the address follows
   // the current request even while the pointer itself is frozen.
   assign addrOut = pop_acc ? (sp_q + 1'b1) : sp_q;

   assign dataBus = oe ? sp_q : {WIDTH{1'bz}};

   assign ovf = ovf_q;
   assign unf = unf_q;

   always_comb begin
      sp_d  = sp_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (wr_acc) begin
         sp_d  = dataBus;
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else if (push_acc) begin
         sp_d = sp_q - 1'b1;
      end else if (pop_acc) begin
         sp_d = sp_q + 1'b1;
      end
      if (push_rej) ovf_d = 1'b1;
      if (pop_rej)  unf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q  <= BASE_VAL;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (clk_en) begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

endmodule

// File: tb/tb_stack_pointer.sv
module tb_stack_pointer;

`ifdef SP_BOUNDS_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   // 8-bit default instance
   logic       clk_en = 1'b0, oe = 1'b0, wr = 1'b0, push = 1'b0, pop = 1'b0;
   logic       bus_en = 1'b0;
   logic [7:0] bus_val = 8'h00;
   tri   [7:0] dataBus;
   logic [7:0] addrOut;
   logic       full, empty, ovf, unf;

   // 4-bit instance
   logic       en4 = 1'b0, oe4 = 1'b0, wr4 = 1'b0, push4 = 1'b0, pop4 = 1'b0;
   logic       bus4_en = 1'b0;
   logic [3:0] bus4_val = 4'h0;
   tri   [3:0] dataBus4;
   logic [3:0] addr4;
   logic       full4, empty4, ovf4, unf4;

   int n_tests = 0;
   int n_fail  = 0;

   assign dataBus  = bus_en  ? bus_val  : 8'hzz;
   assign dataBus4 = bus4_en ? bus4_val : 4'hz;

   always #5 clk = ~clk;

   stack_pointer #(.WIDTH(8)) u_dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .oe(oe), .wr(wr),
      .push(push), .pop(pop), .dataBus(dataBus), .addrOut(addrOut),
      .full(full), .empty(empty), .ovf(ovf), .unf(unf)
   );

   stack_pointer #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .clk_en(en4), .oe(oe4), .wr(wr4),
      .push(push4), .pop(pop4), .dataBus(dataBus4), .addrOut(addr4),
      .full(full4), .empty(empty4), .ovf(ovf4), .unf(unf4)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset
      repeat (2) tick();
      rst = 1'b0;
      #1;
      check("rst_addr",   16'(addrOut), 16'hFF);
      check("rst_empty",  16'(empty), 16'd1);
      check("rst_full",   16'(full), 16'd0);
      check("rst_ovf",    16'(ovf), 16'd0);
      check("rst_unf",    16'(unf), 16'd0);
      check("rst_addr4",  16'(addr4), 16'hF);
      check("rst_empty4", 16'(empty4), 16'd1);

      // three pushes then a pop
      clk_en = 1'b1;
      push   = 1'b1;
      check("push1_addr", 16'(addrOut), 16'hFF);
      tick();
      check("push2_addr", 16'(addrOut), 16'hFE);
      check("push2_empty", 16'(empty), 16'd0);
      tick();
      check("push3_addr", 16'(addrOut), 16'hFD);
      tick();
      push = 1'b0;
      check("sp_fc", 16'(addrOut), 16'hFC);
      pop = 1'b1;
      #1;
      check("pop_addr", 16'(addrOut), 16'hFD);
      tick();
      pop = 1'b0;
      #1;
      check("sp_fd", 16'(addrOut), 16'hFD);

      // load 01 then push to full, then push past full
      wr = 1'b1; bus_en = 1'b1; bus_val = 8'h01;
      tick();
      wr = 1'b0; bus_en = 1'b0;
      #1;
      check("wr_sp01", 16'(addrOut), 16'h01);
      push = 1'b1;
      tick();
      check("full_sp", 16'(addrOut), 16'h00);
      check("full_flag", 16'(full), 16'd1);
      tick();
      check("ovf_sp",   16'(addrOut), CHK ? 16'h00 : 16'hFF);
      check("ovf_flag", 16'(ovf), CHK ? 16'd1 : 16'd0);
      check("ovf_full", 16'(full), CHK ? 16'd1 : 16'd0);

      // asynchronous reset mid-clock with a push pending
      #3;
      rst = 1'b1;
      #1;
      check("arst_addr",  16'(addrOut), 16'hFF);
      check("arst_empty", 16'(empty), 16'd1);
      check("arst_ovf",   16'(ovf), 16'd0);
      push = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      check("arst_hold", 16'(addrOut), 16'hFF);

      // pop while empty
      pop = 1'b1;
      #1;
      check("unf_addr_pre", 16'(addrOut), CHK ? 16'hFF : 16'h00);
      tick();
      pop = 1'b0;
      #1;
      check("unf_sp",   16'(addrOut), CHK ? 16'hFF : 16'h00);
      check("unf_flag", 16'(unf), CHK ? 16'd1 : 16'd0);

      // load 80 (clears flags), push&pop together
      wr = 1'b1; bus_en = 1'b1; bus_val = 8'h80;
      tick();
      wr = 1'b0; bus_en = 1'b0;
      #1;
      check("wr_clr_unf", 16'(unf), 16'd0);
      push = 1'b1; pop = 1'b1;
      #1;
      check("pp_addr", 16'(addrOut), 16'h80);
      tick();
      pop = 1'b0;
      check("pp_sp",  16'(addrOut), 16'h80);
      check("pp_ovf", 16'(ovf), 16'd0);
      check("pp_unf", 16'(unf), 16'd0);

      // oe with wr: wr ignored, push proceeds, bus carries SP
      oe = 1'b1; wr = 1'b1;
      #1;
      check("oe_bus80", 16'(dataBus), 16'h80);
      tick();
      push = 1'b0; wr = 1'b0;
      #1;
      check("oe_sp7f",  16'(addrOut), 16'h7F);
      check("oe_bus7f", 16'(dataBus), 16'h7F);
      oe = 1'b0;

      // clk_en low: pointer frozen, address still tracks
      clk_en = 1'b0;
      push   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hold_push", 16'(addrOut), 16'h7F);
      end
      push = 1'b0; pop = 1'b1;
      #1;
      check("hold_pop_addr", 16'(addrOut), 16'h80);
      tick();
      pop = 1'b0;
      #1;
      check("hold_pop_sp", 16'(addrOut), 16'h7F);

      // WIDTH=4: load 1, push twice
      en4 = 1'b1; wr4 = 1'b1; bus4_en = 1'b1; bus4_val = 4'h1;
      tick();
      wr4 = 1'b0; bus4_en = 1'b0; push4 = 1'b1;
      tick();
      check("w4_sp0",   16'(addr4), 16'h0);
      check("w4_full",  16'(full4), 16'd1);
      tick();
      push4 = 1'b0;
      #1;
      check("w4_wrap", 16'(addr4), CHK ? 16'h0 : 16'hF);
      check("w4_ovf",  16'(ovf4), CHK ? 16'd1 : 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
